// File: rtl/any1_bitfield_packer.sv
// any1_bitfield_packer
// Streaming bitfield inserter. The packer takes fields of 1..DWIDTH bits and packs
// them LSB-first into DWIDTH-bit words. A field may straddle a word boundary. A flush
// emits the pending partial word, zero-padded above its valid bits.
// Optional feature: define ANY1_BFPACK_WCNT_EN to enable the word-transfer counter on
// wcnt_o. When the macro is undefined, wcnt_o is tied to zero.
module any1_bitfield_packer #(
    parameter int DWIDTH = 64,
    parameter int WW     = $clog2(DWIDTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fld_valid_i,
    output logic              fld_ready_o,
    input  logic [DWIDTH-1:0] fld_dat_i,
    input  logic [WW-1:0]     fld_wid_i,
    input  logic              flush_i,
    output logic              flush_done_o,
    output logic              wrd_valid_o,
    input  logic              wrd_ready_i,
    output logic [DWIDTH-1:0] wrd_dat_o,
    output logic [WW:0]       wrd_bits_o,
    output logic [31:0]       wcnt_o
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [DWIDTH-1:0]   acc;
    logic [WW-1:0]       fill;

    logic                out_free;
    logic                accept;
    logic                xfer;
    logic [WW:0]         w;
    logic [DWIDTH-1:0]   f;
    logic [WW+1:0]       sum;
    logic                full;
    logic [2*DWIDTH-1:0] cmb;

    // Keeps the low 'width' bits. A width of DWIDTH shifts every ones bit out, so the
    // mask becomes all ones.
    function automatic logic [DWIDTH-1:0] field_mask(input logic [WW:0] width);
        return ~({DWIDTH{1'b1}} << width);
    endfunction

    assign out_free = ~wrd_valid_o | wrd_ready_i;
    assign accept   = fld_valid_i & fld_ready_o;
    assign xfer     = wrd_valid_o & wrd_ready_i;
    assign w        = {1'b0, fld_wid_i} + (WW+1)'(1);
    assign f        = fld_dat_i & field_mask(w);
    assign sum      = {2'b00, fill} + {1'b0, w};
    assign full     = (sum >= (WW+2)'(DWIDTH));
    assign cmb      = {{DWIDTH{1'b0}}, acc} | ({{DWIDTH{1'b0}}, f} << fill);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= RUN;
        else       state <= state_nxt;
    end

    // Next state: a flush request leaves RUN and completes once the output slot is free
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush_i)  state_nxt = FLUSH;
            FLUSH:   if (out_free) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Field handshake: fields are accepted only in RUN when the output slot can take a word
    always_comb begin
        fld_ready_o = (state == RUN) & out_free;
    end

    // Accumulator and output word register; a load in the same cycle as a transfer wins.
    // DWIDTH is a power of two, so sum[WW-1:0] equals sum-DWIDTH on overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc          <= '0;
            fill         <= '0;
            wrd_valid_o  <= 1'b0;
            wrd_dat_o    <= '0;
            wrd_bits_o   <= '0;
            flush_done_o <= 1'b0;
        end else begin
            flush_done_o <= 1'b0;
            if (xfer) wrd_valid_o <= 1'b0;
            if (state == RUN) begin
                if (accept) begin
                    fill <= sum[WW-1:0];
                    if (full) begin
                        wrd_dat_o   <= cmb[DWIDTH-1:0];
                        wrd_bits_o  <= (WW+1)'(DWIDTH);
                        wrd_valid_o <= 1'b1;
                        acc         <= cmb[2*DWIDTH-1:DWIDTH];
                    end else begin
                        acc <= cmb[DWIDTH-1:0];
                    end
                end
            end else if (out_free) begin
                if (fill != '0) begin
                    wrd_dat_o   <= acc;
                    wrd_bits_o  <= {1'b0, fill};
                    wrd_valid_o <= 1'b1;
                end
                acc          <= '0;
                fill         <= '0;
                flush_done_o <= 1'b1;
            end
        end
    end

`ifdef ANY1_BFPACK_WCNT_EN
    // Words-emitted counter: counts every transfer and wraps naturally at 2^32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     wcnt_o <= '0;
        else if (xfer) wcnt_o <= wcnt_o + 32'd1;
    end
`else
    assign wcnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_any1_bitfield_packer.sv
// tb_any1_bitfield_packer
// The reference model is a plain bit queue. Accepted fields append their bits LSB-first.
// Every 64 queued bits form one expected word, and a flush turns the remaining bits
// into a partial word. Observed words are compared in order with the expected words.
module tb_any1_bitfield_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fld_valid;
    logic        fld_ready;
    logic [63:0] fld_dat;
    logic [5:0]  fld_wid;
    logic        flush;
    logic        flush_done;
    logic        wrd_valid;
    logic        wrd_ready;
    logic [63:0] wrd_dat;
    logic [6:0]  wrd_bits;
    logic [31:0] wcnt;

    any1_bitfield_packer #(.DWIDTH(64), .WW(6)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fld_valid_i  (fld_valid),
        .fld_ready_o  (fld_ready),
        .fld_dat_i    (fld_dat),
        .fld_wid_i    (fld_wid),
        .flush_i      (flush),
        .flush_done_o (flush_done),
        .wrd_valid_o  (wrd_valid),
        .wrd_ready_i  (wrd_ready),
        .wrd_dat_o    (wrd_dat),
        .wrd_bits_o   (wrd_bits),
        .wcnt_o       (wcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        int          n;
    } word_t;

    bit          bitq[$];
    word_t       wq[$];
    bit          fl_pend;
    bit          exp_done;
    bit          exp_ready;
    bit          last_acc;
    logic [31:0] mcnt;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        bitq.delete();
        wq.delete();
        fl_pend  = 1'b0;
        exp_done = 1'b0;
        mcnt     = '0;
    endfunction

    function automatic void take_word(input int n);
        word_t x;
        x.d = '0;
        x.n = n;
        for (int i = 0; i < n; i++) x.d[i] = bitq.pop_front();
        wq.push_back(x);
    endfunction

    // Check the settled outputs at the falling edge, then advance the model over the rising edge
    task automatic tick();
        bit of;
        @(negedge clk);
        of        = (wq.size() == 0) || wrd_ready;
        exp_ready = !fl_pend && of;
        chk("fld_ready", 64'(fld_ready), 64'(exp_ready));
        chk("wrd_valid", 64'(wrd_valid), 64'(wq.size() != 0));
        if (wq.size() != 0) begin
            chk("wrd_dat", wrd_dat, wq[0].d);
            chk("wrd_bits", 64'(wrd_bits), 64'(wq[0].n));
        end
        chk("flush_done", 64'(flush_done), 64'(exp_done));
`ifdef ANY1_BFPACK_WCNT_EN
        chk("wcnt", 64'(wcnt), 64'(mcnt));
`else
        chk("wcnt", 64'(wcnt), 64'd0);
`endif
        exp_done = 1'b0;
        last_acc = 1'b0;
        if (wq.size() != 0 && wrd_ready) begin
            void'(wq.pop_front());
            mcnt = mcnt + 32'd1;
        end
        if (fld_valid && exp_ready) begin
            last_acc = 1'b1;
            for (int i = 0; i <= int'(fld_wid); i++) bitq.push_back(fld_dat[i]);
            if (bitq.size() >= 64) take_word(64);
        end
        if (fl_pend) begin
            if (of) begin
                if (bitq.size() > 0) take_word(bitq.size());
                exp_done = 1'b1;
                fl_pend  = 1'b0;
            end
        end else if (flush) begin
            fl_pend = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_field(input logic [5:0] wid, input logic [63:0] dat);
        fld_valid = 1'b1;
        fld_wid   = wid;
        fld_dat   = dat;
        last_acc  = 1'b0;
        for (int i = 0; i < 64 && !last_acc; i++) tick();
        chk("send_accept", 64'(last_acc), 64'd1);
        fld_valid = 1'b0;
    endtask

    task automatic do_flush();
        bit seen;
        seen  = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 32 && !seen; i++) begin
            tick();
            seen = flush_done;
        end
        chk("flush_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        fld_valid = 1'b0;
        fld_dat   = '0;
        fld_wid   = '0;
        flush     = 1'b0;
        wrd_ready = 1'b1;
        model_reset();
        last_acc  = 1'b0;
        exp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(wrd_valid), 64'd0);
        chk("rst_dat", wrd_dat, 64'd0);
        chk("rst_bits", 64'(wrd_bits), 64'd0);
        chk("rst_done", 64'(flush_done), 64'd0);
        chk("rst_wcnt", 64'(wcnt), 64'd0);
        chk("rst_ready", 64'(fld_ready), 64'd1);
        rst = 1'b0;
        tick();

        // Eight byte fields form one word
        for (int i = 1; i <= 8; i++) send_field(6'd7, 64'(i));
        chk("bytes_valid", 64'(wrd_valid), 64'd1);
        chk("bytes_dat", wrd_dat, 64'h0807060504030201);
        chk("bytes_bits", 64'(wrd_bits), 64'd64);

        // A field straddles the word boundary, and the flush emits the leftover nibble
        send_field(6'd59, '1);
        send_field(6'd7, 64'hA5);
        chk("straddle_dat", wrd_dat, 64'h5FFFFFFFFFFFFFFF);
        do_flush();
        chk("straddle_fl_dat", wrd_dat, 64'h000000000000000A);
        chk("straddle_fl_bits", 64'(wrd_bits), 64'd4);
        chk("straddle_fl_done", 64'(flush_done), 64'd1);

        // Bits above the field width are masked off
        send_field(6'd3, '1);
        do_flush();
        chk("mask_dat", wrd_dat, 64'hF);
        chk("mask_bits", 64'(wrd_bits), 64'd4);

        // With backpressure the held word stays stable; on release the pending field
        // loads the next word with no bubble
        for (int i = 0; i < 8; i++) send_field(6'd7, 64'(8'h10 + i));
        wrd_ready = 1'b0;
        fld_valid = 1'b1;
        fld_wid   = 6'd63;
        fld_dat   = 64'hCAFEF00DDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ready", 64'(fld_ready), 64'd0);
            chk("bp_dat", wrd_dat, 64'h1716151413121110);
        end
        wrd_ready = 1'b1;
        tick();
        chk("bp_acc", 64'(last_acc), 64'd1);
        chk("bp_next_valid", 64'(wrd_valid), 64'd1);
        chk("bp_next_dat", wrd_dat, 64'hCAFEF00DDEADBEEF);
        fld_valid = 1'b0;
        tick();

        // A reset in mid-word discards the pending bits
        send_field(6'd11, 64'hABC);
        rst = 1'b1;
        #2;
        chk("rstmid_valid", 64'(wrd_valid), 64'd0);
        chk("rstmid_ready", 64'(fld_ready), 64'd1);
        rst = 1'b0;
        model_reset();
        do_flush();
        chk("rstmid_noword", 64'(wrd_valid), 64'd0);

        // Two full-width fields
        send_field(6'd63, 64'h123456789ABCDEF0);
        chk("fw1_dat", wrd_dat, 64'h123456789ABCDEF0);
        send_field(6'd63, 64'h0);
        chk("fw2_dat", wrd_dat, 64'h0);
        chk("fw2_valid", 64'(wrd_valid), 64'd1);
        tick();
`ifdef ANY1_BFPACK_WCNT_EN
        chk("fw_wcnt", 64'(wcnt), 64'd2);
`else
        chk("fw_wcnt", 64'(wcnt), 64'd0);
`endif

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            fld_valid = ($urandom_range(0, 3) != 0);
            fld_wid   = ($urandom_range(0, 5) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
            fld_dat   = {$urandom, $urandom};
            wrd_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            tick();
        end

        // Drain the remaining bits
        fld_valid = 1'b0;
        wrd_ready = 1'b1;
        flush     = 1'b0;
        tick();
        tick();
        do_flush();
        tick();
        tick();
        chk("drain_empty", 64'(wq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
